// File: rtl/uart_rx_cfg_if.sv
// Receive-side handshake bundle for uart_rx_cfg: received word, valid/ready
// and the per-word status flags.
`timescale 1ns/1ps
interface uart_rx_cfg_if #(
    parameter int unsigned DATABITS = 8
);
    logic [DATABITS-1:0] rx_data;
    logic                rx_valid;
    logic                rx_ready;
    logic                parity_error;
    logic                framing_error;
    logic                break_detect;
    logic                overrun_error;

    modport master (
        output rx_data, rx_valid, parity_error, framing_error, break_detect, overrun_error,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, parity_error, framing_error, break_detect, overrun_error,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable oversampling UART receiver with valid/ready holding register.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit mid-point.
`timescale 1ns/1ps
module uart_rx_cfg #(
    parameter int unsigned DATABITS   = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        baud_tick,
    input  logic        rx_line,
    input  logic [1:0]  parity_mode,
    input  logic        stop2,
    uart_rx_cfg_if.master rx_if
);
    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATABITS + 1);
    localparam logic [CW-1:0] LAST_C  = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] MID_C   = CW'(OVERSAMPLE / 2);
    localparam logic [BW-1:0] DLAST_C = BW'(DATABITS - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_sample_cnt;
    logic [BW-1:0]         r_bit_cnt;
    logic [DATABITS-1:0]   r_shift;
    logic [1:0]            r_pmode;
    logic                  r_stop2;
    logic                  r_par_bit;
    logic                  r_pe_pend;
    logic                  r_fe_pend;

    logic [DATABITS-1:0]   r_rx_data;
    logic                  r_rx_valid;
    logic                  r_parity_error;
    logic                  r_framing_error;
    logic                  r_break_detect;
    logic                  r_overrun_error;

    logic w_at_smp;
    logic w_bit;
    logic w_par_en;
    logic w_par_exp;
    logic w_last_stop;
    logic w_commit;
    logic w_fe;
    logic w_brk;
    logic w_accept;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0] SMP_C = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] MA_C  = CW'(OVERSAMPLE / 2 - 1);
    logic r_maj_a;
    logic r_maj_b;
    // Decision is taken on the third sample (M+1), so commit moves there too.
    assign w_bit = (r_maj_a & r_maj_b) | (r_maj_a & rx_line) | (r_maj_b & rx_line);
`else
    localparam logic [CW-1:0] SMP_C = MID_C;
    assign w_bit = rx_line;
`endif

    assign w_at_smp    = baud_tick && (r_sample_cnt == SMP_C);
    assign w_par_en    = (r_pmode == 2'b01) || (r_pmode == 2'b10);
    assign w_par_exp   = (r_pmode == 2'b01) ? ^r_shift : ~^r_shift;
    assign w_last_stop = !r_stop2 || (r_bit_cnt == BW'(1));
    assign w_commit    = (r_state == STOP) && w_at_smp && w_last_stop;
    assign w_fe        = r_fe_pend | ~w_bit;
    assign w_brk       = (r_shift == '0) && (!w_par_en || !r_par_bit) && w_fe;
    assign w_accept    = r_rx_valid && rx_if.rx_ready;

    assign rx_if.rx_data       = r_rx_data;
    assign rx_if.rx_valid      = r_rx_valid;
    assign rx_if.parity_error  = r_parity_error;
    assign rx_if.framing_error = r_framing_error;
    assign rx_if.break_detect  = r_break_detect;
    assign rx_if.overrun_error = r_overrun_error;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= IDLE;
            r_sample_cnt    <= '0;
            r_bit_cnt       <= '0;
            r_shift         <= '0;
            r_pmode         <= '0;
            r_stop2         <= 1'b0;
            r_par_bit       <= 1'b0;
            r_pe_pend       <= 1'b0;
            r_fe_pend       <= 1'b0;
            r_rx_data       <= '0;
            r_rx_valid      <= 1'b0;
            r_parity_error  <= 1'b0;
            r_framing_error <= 1'b0;
            r_break_detect  <= 1'b0;
            r_overrun_error <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            r_maj_a         <= 1'b0;
            r_maj_b         <= 1'b0;
`endif
        end else begin
            // A word held and not taken this cycle makes the new frame an overrun.
            if (w_commit) begin
                if (!r_rx_valid || w_accept) begin
                    r_rx_data       <= r_shift;
                    r_parity_error  <= r_pe_pend;
                    r_framing_error <= w_fe;
                    r_break_detect  <= w_brk;
                    r_rx_valid      <= 1'b1;
                    r_overrun_error <= 1'b0;
                end else begin
                    r_overrun_error <= 1'b1;
                end
            end else if (w_accept) begin
                r_rx_valid      <= 1'b0;
                r_overrun_error <= 1'b0;
                r_parity_error  <= 1'b0;
                r_framing_error <= 1'b0;
                r_break_detect  <= 1'b0;
            end

`ifdef UART_RX_MAJORITY_EN
            if (baud_tick && (r_sample_cnt == MA_C))
                r_maj_a <= rx_line;
            if (baud_tick && (r_sample_cnt == MID_C))
                r_maj_b <= rx_line;
`endif

            if (baud_tick) begin
                case (r_state)
                    IDLE: begin
                        if (!rx_line) begin
                            r_state      <= START;
                            r_sample_cnt <= CW'(1);
                            r_bit_cnt    <= '0;
                            r_pmode      <= parity_mode;
                            r_stop2      <= stop2;
                            r_pe_pend    <= 1'b0;
                            r_fe_pend    <= 1'b0;
                            r_par_bit    <= 1'b0;
                        end
                    end
                    START: begin
                        if (w_at_smp && w_bit) begin
                            r_state      <= IDLE;
                            r_sample_cnt <= '0;
                        end else if (r_sample_cnt == LAST_C) begin
                            r_state      <= DATA;
                            r_sample_cnt <= '0;
                            r_bit_cnt    <= '0;
                        end else begin
                            r_sample_cnt <= r_sample_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (w_at_smp) begin
                            for (int unsigned i = 0; i < DATABITS; i++)
                                if (r_bit_cnt == BW'(i))
                                    r_shift[i] <= w_bit;
                        end
                        if (r_sample_cnt == LAST_C) begin
                            r_sample_cnt <= '0;
                            if (r_bit_cnt == DLAST_C) begin
                                r_bit_cnt <= '0;
                                r_state   <= w_par_en ? PARITY : STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end else begin
                            r_sample_cnt <= r_sample_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        if (w_at_smp) begin
                            r_par_bit <= w_bit;
                            if (w_bit != w_par_exp)
                                r_pe_pend <= 1'b1;
                        end
                        if (r_sample_cnt == LAST_C) begin
                            r_sample_cnt <= '0;
                            r_bit_cnt    <= '0;
                            r_state      <= STOP;
                        end else begin
                            r_sample_cnt <= r_sample_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        // r_bit_cnt doubles as the stop-bit index here.
                        if (w_commit) begin
                            r_sample_cnt <= '0;
                            r_state      <= w_bit ? IDLE : WAIT_HIGH;
                        end else begin
                            if (w_at_smp && !w_bit)
                                r_fe_pend <= 1'b1;
                            if (r_sample_cnt == LAST_C) begin
                                r_sample_cnt <= '0;
                                r_bit_cnt    <= r_bit_cnt + 1'b1;
                            end else begin
                                r_sample_cnt <= r_sample_cnt + 1'b1;
                            end
                        end
                    end
                    WAIT_HIGH: begin
                        if (rx_line)
                            r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg (DATABITS=8, OVERSAMPLE=16), baud tick every other clock.
`timescale 1ns/1ps
module tb_uart_rx_cfg;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       r_div = 1'b0;
    logic       baud_tick;
    logic       rx_line = 1'b1;
    logic [1:0] parity_mode = 2'b00;
    logic       stop2 = 1'b0;

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned nwords = 0;
    int unsigned vcycles = 0;
    int unsigned n0;
    int unsigned v0;
    logic [7:0] got_data = '0;
    logic       got_pe = 1'b0;
    logic       got_fe = 1'b0;
    logic       got_brk = 1'b0;

    uart_rx_cfg_if #(.DATABITS(8)) rx_if();

    uart_rx_cfg #(.DATABITS(8), .OVERSAMPLE(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .baud_tick   (baud_tick),
        .rx_line     (rx_line),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .rx_if       (rx_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) r_div <= ~r_div;
    assign baud_tick = r_div;

    always @(negedge clk) begin
        if (rx_if.rx_valid) vcycles++;
        if (rx_if.rx_valid && rx_if.rx_ready) begin
            nwords++;
            got_data = rx_if.rx_data;
            got_pe   = rx_if.parity_error;
            got_fe   = rx_if.framing_error;
            got_brk  = rx_if.break_detect;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ticks(input int unsigned n);
        int unsigned k = 0;
        while (k < n) begin
            @(negedge clk);
            if (baud_tick) begin
                @(posedge clk);
                k++;
            end
        end
        #1;
    endtask

    task automatic send_bit(input logic v);
        rx_line = v;
        wait_ticks(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic pb,
                              input logic s2, input logic st_last);
        parity_mode = pm;
        stop2 = s2;
        send_bit(1'b0);
        for (int unsigned i = 0; i < 8; i++) send_bit(d[i]);
        if (pm == 2'b01 || pm == 2'b10) send_bit(pb);
        if (s2) send_bit(1'b1);
        send_bit(st_last);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rx_if.rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(rx_if.rx_valid), 0);
        chk("rst_data",  32'(rx_if.rx_data), 0);
        chk("rst_pe",    32'(rx_if.parity_error), 0);
        chk("rst_fe",    32'(rx_if.framing_error), 0);
        chk("rst_brk",   32'(rx_if.break_detect), 0);
        chk("rst_ovr",   32'(rx_if.overrun_error), 0);
        reset_n = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);

        // 0xA5 even parity (bit 0), one stop
        n0 = nwords; v0 = vcycles;
        send_frame(8'hA5, 2'b01, 1'b0, 1'b0, 1'b1);
        send_bit(1'b1);
        chk("a5_words",  nwords - n0, 1);
        chk("a5_vcyc",   vcycles - v0, 1);
        chk("a5_data",   32'(got_data), 32'hA5);
        chk("a5_pe",     32'(got_pe), 0);
        chk("a5_fe",     32'(got_fe), 0);
        chk("a5_brk",    32'(got_brk), 0);

        // 0x5A odd parity, wrong parity bit 0
        send_frame(8'h5A, 2'b10, 1'b0, 1'b0, 1'b1);
        send_bit(1'b1);
        chk("5a_data",   32'(got_data), 32'h5A);
        chk("5a_pe",     32'(got_pe), 1);
        chk("5a_fe",     32'(got_fe), 0);

        // 0x33 no parity, two stops, second stop low
        n0 = nwords;
        send_frame(8'h33, 2'b00, 1'b0, 1'b1, 1'b0);
        chk("33_data",   32'(got_data), 32'h33);
        chk("33_fe",     32'(got_fe), 1);
        chk("33_brk",    32'(got_brk), 0);
        chk("33_st_wh",  32'(int'(dut.r_state)), 5);
        wait_ticks(32);
        chk("33_noretr", nwords - n0, 1);
        chk("33_st_wh2", 32'(int'(dut.r_state)), 5);
        send_bit(1'b1);
        chk("33_st_idl", 32'(int'(dut.r_state)), 0);
        send_frame(8'h0F, 2'b00, 1'b0, 1'b0, 1'b1);
        send_bit(1'b1);
        chk("0f_data",   32'(got_data), 32'h0F);
        chk("0f_fe",     32'(got_fe), 0);

        // line held low 20 bit times, even parity -> single break word
        n0 = nwords;
        parity_mode = 2'b01; stop2 = 1'b0;
        rx_line = 1'b0;
        wait_ticks(20 * 16);
        chk("brk_words", nwords - n0, 1);
        chk("brk_data",  32'(got_data), 0);
        chk("brk_brk",   32'(got_brk), 1);
        chk("brk_fe",    32'(got_fe), 1);
        chk("brk_pe",    32'(got_pe), 0);
        send_bit(1'b1);
        chk("brk_words2", nwords - n0, 1);
        send_frame(8'h81, 2'b01, 1'b0, 1'b0, 1'b1);
        send_bit(1'b1);
        chk("81_words",  nwords - n0, 2);
        chk("81_data",   32'(got_data), 32'h81);
        chk("81_brk",    32'(got_brk), 0);

        // overrun: 0x11 held, 0x22 dropped
        rx_if.rx_ready = 1'b0;
        send_frame(8'h11, 2'b00, 1'b0, 1'b0, 1'b1);
        send_bit(1'b1);
        send_frame(8'h22, 2'b00, 1'b0, 1'b0, 1'b1);
        send_bit(1'b1);
        chk("ovr_valid", 32'(rx_if.rx_valid), 1);
        chk("ovr_data",  32'(rx_if.rx_data), 32'h11);
        chk("ovr_flag",  32'(rx_if.overrun_error), 1);
        @(negedge clk); #1;
        rx_if.rx_ready = 1'b1;
        @(negedge clk);
        chk("ovr_clr_v", 32'(rx_if.rx_valid), 0);
        chk("ovr_clr_o", 32'(rx_if.overrun_error), 0);
        chk("ovr_hold",  32'(rx_if.rx_data), 32'h11);

        // start-bit glitch of 4 ticks
        n0 = nwords; v0 = vcycles;
        rx_line = 1'b0;
        wait_ticks(4);
        rx_line = 1'b1;
        wait_ticks(32);
        chk("gl_words",  nwords - n0, 0);
        chk("gl_vcyc",   vcycles - v0, 0);
        chk("gl_state",  32'(int'(dut.r_state)), 0);

        // reset mid-DATA with an unread word pending
        rx_if.rx_ready = 1'b0;
        send_frame(8'h7E, 2'b01, 1'b1, 1'b0, 1'b1);
        send_bit(1'b1);
        chk("7e_valid",  32'(rx_if.rx_valid), 1);
        chk("7e_data",   32'(rx_if.rx_data), 32'h7E);
        chk("7e_pe",     32'(rx_if.parity_error), 1);
        parity_mode = 2'b00;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        reset_n = 1'b0;
        #3;
        chk("mr_valid",  32'(rx_if.rx_valid), 0);
        chk("mr_data",   32'(rx_if.rx_data), 0);
        chk("mr_pe",     32'(rx_if.parity_error), 0);
        chk("mr_fe",     32'(rx_if.framing_error), 0);
        chk("mr_brk",    32'(rx_if.break_detect), 0);
        chk("mr_ovr",    32'(rx_if.overrun_error), 0);
        chk("mr_state",  32'(int'(dut.r_state)), 0);
        rx_line = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        rx_if.rx_ready = 1'b1;
        n0 = nwords;
        send_frame(8'hC3, 2'b00, 1'b0, 1'b0, 1'b1);
        send_bit(1'b1);
        chk("c3_words",  nwords - n0, 1);
        chk("c3_data",   32'(got_data), 32'hC3);
        chk("c3_pe",     32'(got_pe), 0);
        chk("c3_fe",     32'(got_fe), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
- Parametrised, runtime-configurable UART receiver; successor to the fixed 8-bit/even-parity receiver.
- Adds configurable data width and oversample ratio, runtime parity mode and stop-bit count, framing/overrun/break detection, and a valid/ready output holding register.
- Sits between the baud-tick generator and the RX FIFO / register interface.

Parameters:
- DATABITS, 8, data bits per frame; legal range 5..9.
- OVERSAMPLE, 16, baud_tick pulses per bit; even, >= 8. Mid-point M = OVERSAMPLE/2.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- baud_tick  in  1  single-cycle enable at OVERSAMPLE x baud rate
- rx_line  in  1  serial input, already synchronised; idle high
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 none
- stop2  in  1  1 = two stop bits expected
- rx_data  out  DATABITS  received word, LSB first on the line
- rx_valid  out  1  word available
- rx_ready  in  1  consumer accepts the word
- parity_error  out  1  qualifies rx_data
- framing_error  out  1  qualifies rx_data
- break_detect  out  1  qualifies rx_data
- overrun_error  out  1  at least one frame was dropped while rx_valid was held

Behaviour:
- Reset (async assert, sync release): state IDLE, all counters 0, all outputs 0.
- All state advances only on clk edges with baud_tick=1. The output handshake is evaluated every clk.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- Bit-period counter sample_cnt runs 0..OVERSAMPLE-1 and wraps to 0 at the end of each bit.
- IDLE: tick with rx_line=0 -> START, sample_cnt=1.
  - parity_mode and stop2 are latched here; mid-frame changes are ignored.
- START: at sample_cnt==M:
  - rx_line=1 -> IDLE (glitch rejected, no output).
  - rx_line=0 -> keep counting. At wrap -> DATA with bit_cnt=0.
- DATA: sample at M into shift position bit_cnt.
  - At wrap, bit_cnt++.
  - After bit DATABITS-1 -> PARITY if the latched mode is even or odd, else STOP.
- PARITY: sample at M.
  - Expected bit: even -> ^data; odd -> ~^data.
  - Mismatch sets a pending parity error.
  - At wrap -> STOP.
- STOP: sample at M; a low sample sets pending framing error.
  - If stop2, the first stop bit wraps into a second STOP bit, which is also checked.
  - The frame commits at M of the last stop bit (not at the wrap), so resync to the next start bit is possible.
  - After commit: -> WAIT_HIGH if the last stop sample was 0, else IDLE.
- WAIT_HIGH: stay until a tick with rx_line=1, then -> IDLE. This prevents a held-low line from retriggering.
- break_detect on commit: data==0 AND (parity bit sampled 0 or no parity) AND framing error.
- Commit, rx_valid=0 or accepted the same cycle (rx_valid & rx_ready):
  - Load rx_data and the three error flags.
  - rx_valid=1 on the next clk after the commit tick (latency 1 clk).
- Commit, rx_valid=1 and not accepted that cycle:
  - Drop the new frame; rx_data and its flags are unchanged.
  - Set overrun_error=1.
- rx_valid & rx_ready with no commit in the same cycle:
  - rx_valid=0.
  - overrun_error cleared.
  - Error flags cleared.
- rx_data holds its last value while rx_valid=0.
- reset_n low mid-frame: immediate abort to IDLE; the partial frame is lost, and rx_valid plus any unread word are cleared.
- Widths:
  - bit_cnt is $clog2(DATABITS+1) bits.
  - sample_cnt is $clog2(OVERSAMPLE) bits.
  - Parity is XOR over exactly DATABITS bits.

Optional Feature:
- UART_RX_MAJORITY_EN defined: every sampled bit (start validate, data, parity, stop) is the 2-of-3 majority of the rx_line values at ticks M-1, M and M+1 of that bit.
  - The frame commit point moves to M+1 of the last stop bit.
  - The START glitch check also uses the majority.
- UART_RX_MAJORITY_EN undefined: single sample at M; there is no majority logic or extra sample registers.

Test Plan (DATABITS=8, OVERSAMPLE=16):
- 0xA5, even parity, parity bit 0, 1 stop, rx_ready=1 -> rx_valid one clk, rx_data=0xA5, all error flags 0.
- 0x5A, odd parity, parity bit sent 0 (correct is 1) -> rx_data=0x5A, parity_error=1, framing_error=0.
- 0x33, parity none, stop2=1, second stop bit driven low -> framing_error=1, state enters WAIT_HIGH, then returns to IDLE once the line goes high.
- rx_line held low for 20 bit times, even parity -> exactly one word: rx_data=0x00, break_detect=1, framing_error=1. No second rx_valid until the line goes high and a new start bit arrives.
- rx_ready=0, frames 0x11 then 0x22 -> rx_data stays 0x11, overrun_error=1. Raise rx_ready -> rx_valid=0 and overrun_error=0 on the next clk.
- rx_line low for 4 ticks then high -> no rx_valid, state back to IDLE. Separately, reset_n pulsed low mid-DATA -> all outputs 0, and the next full frame 0xC3 is received correctly.
